mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter_pkg.sv | 20 ++
 rtl/mux2_arbiter_mux2.sv | 13 +
 rtl/mux2_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux2_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester arbiter in front of mux2.
// Optional build macro: MUX2_ARB_RR_EN (round-robin ties and burst limit on both ports).
package mux2_arbiter_pkg;

    // Width of the per-ownership transfer counter.
    localparam int unsigned ARB_CNT_W = 8;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Ownership state that corresponds to a grant index.
    function automatic arb_state_t own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// Parameterized 2:1 multiplexer; s_i selects d1_i when high.
module mux2 #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] d0_i,
    input  logic [width-1:0] d1_i,
    input  logic             s_i,
    output logic [width-1:0] y_o
);

    assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-stream valid/ready arbiter feeding mux2, with a registered output stage.
// Build macro MUX2_ARB_RR_EN: when defined, IDLE ties alternate and the burst
// limit applies to both owners; when undefined, port 0 has fixed priority and
// only owner 1 is burst-limited.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned burst = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [width-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [width-1:0] y,
    output logic             yv,
    input  logic             yr,
    output logic             s
);

    localparam logic [ARB_CNT_W-1:0] BURST_CNT = ARB_CNT_W'(burst);

    arb_state_t             state_q, state_d;
    logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
    logic [width-1:0]       y_q, y_d;
    logic                   yv_q, yv_d;
`ifdef MUX2_ARB_RR_EN
    logic                   last_q, last_d;
`endif

    logic                   open_c;
    logic                   own_idx_c;
    logic                   own_v_c;
    logic                   oth_v_c;
    logic                   limit_c;
    logic                   in_budget_c;
    logic                   tie_c;
    logic                   grant_c;
    logic                   xfer_c;
    logic [width-1:0]       mux_y_c;

    // Output register can accept a word when empty or being drained this cycle.
    assign open_c = ~yv_q | yr;

    // Grant selection: owner keeps the grant while valid and within budget.
    always_comb begin
        own_idx_c   = (state_q == OWN1);
        own_v_c     = own_idx_c ? v1 : v0;
        oth_v_c     = own_idx_c ? v0 : v1;
`ifdef MUX2_ARB_RR_EN
        limit_c     = 1'b1;
        tie_c       = ~last_q;
`else
        limit_c     = own_idx_c;
        tie_c       = 1'b0;
`endif
        in_budget_c = ~limit_c | (cnt_q < BURST_CNT);
        grant_c     = 1'b0;
        if (state_q == IDLE) begin
            if (v0 & v1) begin
                grant_c = tie_c;
            end else begin
                grant_c = v1;
            end
        end else if (own_v_c & in_budget_c) begin
            grant_c = own_idx_c;
        end else if (oth_v_c) begin
            grant_c = ~own_idx_c;
        end else begin
            grant_c = own_idx_c;
        end
    end

    assign s      = grant_c;
    assign r0     = ~reset & open_c & ~grant_c;
    assign r1     = ~reset & open_c &  grant_c;
    assign xfer_c = (v0 & r0) | (v1 & r1);

    // Data path: grant drives the mux select.
    mux2 #(
        .width (width)
    ) u_mux2 (
        .d0_i (d0),
        .d1_i (d1),
        .s_i  (grant_c),
        .y_o  (mux_y_c)
    );

    // Next-state: ownership, burst counter and output register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        yv_d    = yv_q;
`ifdef MUX2_ARB_RR_EN
        last_d  = last_q;
`endif
        if (xfer_c) begin
            y_d     = mux_y_c;
            yv_d    = 1'b1;
            state_d = own_state(grant_c);
`ifdef MUX2_ARB_RR_EN
            last_d  = grant_c;
`endif
            if (state_q == own_state(grant_c)) begin
                // Same owner continues: count up, saturating at the burst limit.
                cnt_d = (cnt_q < BURST_CNT) ? cnt_q + ARB_CNT_W'(1) : cnt_q;
            end else begin
                cnt_d = ARB_CNT_W'(1);
            end
        end else if (open_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            yv_d    = 1'b0;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
`ifdef MUX2_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
`ifdef MUX2_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign y  = y_q;
    assign yv = yv_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: a transaction-level reference model
// predicts grants and readies; accepted words are queued and checked by a
// separate monitor when the output handshake completes.
module tb_mux2_arbiter;

    localparam int unsigned W = 8;
    localparam int B = 4;

`ifdef MUX2_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d0, d1;
    logic         v0, v1, yr;
    logic         r0, r1, yv, s;
    logic [W-1:0] y;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: who owns the output, how many words in a row, last winner.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 1;
    bit m_yv    = 1'b0;

    always #5 clk = ~clk;

    mux2_arbiter #(
        .width (W),
        .burst (B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d0    (d0),
        .v0    (v0),
        .r0    (r0),
        .d1    (d1),
        .v1    (v1),
        .r1    (r1),
        .y     (y),
        .yv    (yv),
        .yr    (yr),
        .s     (s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who should win: the current owner stays while it wants more and has not
    // used up its run; otherwise a waiting contender takes over.
    function automatic int model_grant(input bit a0, input bit a1);
        bit want_own, want_oth, capped;
        if (m_owner < 0) begin
            if (a0 && a1) return RR ? (1 - m_last) : 0;
            return a1 ? 1 : 0;
        end
        want_own = (m_owner == 0) ? a0 : a1;
        want_oth = (m_owner == 0) ? a1 : a0;
        capped   = (RR || m_owner == 1) && (m_cnt >= B);
        if (want_own && !capped) return m_owner;
        if (want_oth) return 1 - m_owner;
        return m_owner;
    endfunction

    // One clock of stimulus; predictions compared mid-cycle, model advanced for the next edge.
    task automatic cycle(input bit rst, input bit a0, input logic [W-1:0] x0,
                         input bit a1, input logic [W-1:0] x1, input bit cr);
        int g;
        bit open, want;
        @(posedge clk);
        #1;
        reset = rst; v0 = a0; d0 = x0; v1 = a1; d1 = x1; yr = cr;
        @(negedge clk);
        check("yv", {31'd0, yv}, {31'd0, m_yv});
        g    = model_grant(a0, a1);
        open = !m_yv || cr;
        check("r0", {31'd0, r0}, {31'd0, (!rst && open && g == 0)});
        check("r1", {31'd0, r1}, {31'd0, (!rst && open && g == 1)});
        if (!rst && (a0 || a1)) check("s", {31'd0, s}, g);
        want = (g == 0) ? a0 : a1;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_yv = 1'b0;
            exp_q.delete();
        end else if (want && open) begin
            exp_q.push_back((g == 0) ? x0 : x1);
            m_yv    = 1'b1;
            m_cnt   = (m_owner == g) ? ((m_cnt < B) ? m_cnt + 1 : m_cnt) : 1;
            m_owner = g;
            m_last  = g;
        end else if (open) begin
            m_owner = -1; m_cnt = 0; m_yv = 1'b0;
        end
    endtask

    // Monitor: every completed output handshake must deliver the oldest accepted word.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (yv === 1'b1 && yr === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL y_extra: got %0h with no word expected at %0t", y, $time);
            end else begin
                e = exp_q.pop_front();
                check("y", 32'(y), 32'(e));
            end
        end
    end

    initial begin
        int n;
        bit rst, a0, a1, cr;
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; yr = 1'b0;

        // Reset then a single word from port 0.
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        cycle(0, 1, 8'hA5, 0, 8'h00, 1);
        check("first_r0", {31'd0, r0}, 1);
        check("first_s", {31'd0, s}, 0);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        check("first_y", 32'(y), 32'hA5);
        check("first_yv", {31'd0, yv}, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Both valid continuously from a fresh reset.
        cycle(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, W'(8'h10 + i), 1, W'(8'h90 + i), 1);
            if (RR) check("rr_pattern", {31'd0, s}, ((i % 8) < 4) ? 0 : 1);
            else begin
                check("prio_s", {31'd0, s}, 0);
                check("prio_r1", {31'd0, r1}, 0);
            end
        end
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Port 0 alone for 10 cycles: one transfer every cycle.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, W'(8'h20 + i), 0, 8'h00, 1);
            if (r0 === 1'b1) n++;
        end
        check("solo_count", n, 10);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Backpressure holds 3C and blocks both readies.
        cycle(0, 1, 8'h3C, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h41, 1, 8'hC1, 0);
            check("stall_y", 32'(y), 32'h3C);
            check("stall_r", {30'd0, r1, r0}, 0);
        end
        cycle(0, 1, 8'h42, 1, 8'hC2, 1);
        check("resume_r", {31'd0, (r0 | r1)}, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Reset mid-burst, then first tie goes to port 0.
        cycle(0, 1, 8'h51, 0, 8'h00, 1);
        cycle(0, 1, 8'h52, 0, 8'h00, 1);
        cycle(1, 1, 8'h53, 1, 8'hD3, 0);
        cycle(0, 1, 8'h54, 1, 8'hD4, 1);
        check("post_reset_yv", {31'd0, yv}, 0);
        check("post_reset_tie", {31'd0, s}, 0);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0, 8'h00, 1);

        // Randomized traffic with backpressure and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            a0  = ($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 3) != 0);
            cr  = rst ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(rst, a0, W'($urandom), a1, W'($urandom), cr);
        end

        // Drain the output register.
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 8'h00, 1);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
